// File: rtl/serial_twos_complement.sv
// Bit-serial PASS / NEGATE / ABS unit: one word in flight, processed LSB-first
// with the copy-through-first-one, invert-thereafter two's complement rule.
module serial_twos_complement #(
    parameter int W  = 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] In,
    input  logic [1:0]   mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Out,
    output logic         ovf,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);
    localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic          inv_q, inv_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic [W-1:0]  data_q, data_d;
    logic [W-1:0]  out_q, out_d;
    logic          ovf_q, ovf_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic          inv_en_s;
    logic          obit_s;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        seen_d     = seen_q;
        inv_d      = inv_q;
        ovf_pend_d = ovf_pend_q;
        data_d     = data_q;
        out_d      = out_q;
        ovf_d      = ovf_q;
        inv_en_s   = (mode == 2'b01) || ((mode == 2'b10) && In[W-1]);
        obit_s     = data_q[0] ^ (inv_q & seen_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = SHIFT;
                    cnt_d      = {CW{1'b0}};
                    seen_d     = 1'b0;
                    data_d     = In;
                    inv_d      = inv_en_s;
                    // Only the most-negative word maps onto itself when inverted.
                    ovf_pend_d = inv_en_s && (In == MOST_NEG);
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d = data_q >> 1;
                out_d  = {obit_s, out_q[W-1:1]};
                seen_d = seen_q | data_q[0];
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    ovf_d   = ovf_pend_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d == SHIFT);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            seen_q      <= 1'b0;
            inv_q       <= 1'b0;
            ovf_pend_q  <= 1'b0;
            data_q      <= {W{1'b0}};
            out_q       <= {W{1'b0}};
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            inv_q       <= inv_d;
            ovf_pend_q  <= ovf_pend_d;
            data_q      <= data_d;
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign Out       = out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_twos_complement.sv
// Directed, table-driven bench for serial_twos_complement (W=4 and W=8 instances).
module tb_serial_twos_complement;

    logic       clk;
    logic       rst_n;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, ovf4, busy4;
    logic [3:0] in4, out4;
    logic [1:0] mode4;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, ovf8, busy8;
    logic [7:0] in8, out8;
    logic [1:0] mode8;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] in_v;
        logic [1:0] mode_v;
        logic [3:0] exp_out;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [0:21];

    serial_twos_complement #(.W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .In(in4), .mode(mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .Out(out4), .ovf(ovf4),
        .busy(busy4)
    );

    serial_twos_complement #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .In(in8), .mode(mode8),
        .out_valid(out_valid8), .out_ready(out_ready8), .Out(out8), .ovf(ovf8),
        .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic run_word4(input logic [3:0] v, input logic [1:0] m,
                             input logic [3:0] exp_o, input logic exp_v,
                             input bit scramble);
        int lat;
        in_valid4  = 1'b1;
        in4        = v;
        mode4      = m;
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        if (scramble) begin
            in4   = ~v;
            mode4 = 2'b00;
        end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                check("busy_in_shift", {31'd0, busy4}, 32'd1);
                check("in_ready_low_in_shift", {31'd0, in_ready4}, 32'd0);
            end
            if (out_valid4) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 32'd4);
        check("out", {28'd0, out4}, {28'd0, exp_o});
        check("ovf", {31'd0, ovf4}, {31'd0, exp_v});
        @(posedge clk);
        #1;
        check("in_ready_after_done", {31'd0, in_ready4}, 32'd1);
        check("out_valid_drop", {31'd0, out_valid4}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        checks = 0;
        failures = 0;
        in_valid4 = 1'b0; in4 = 4'd0; mode4 = 2'b00; out_ready4 = 1'b0;
        in_valid8 = 1'b0; in8 = 8'd0; mode8 = 2'b00; out_ready8 = 1'b0;

        for (int i = 0; i < 16; i++) begin
            vecs[i].in_v    = 4'(i);
            vecs[i].mode_v  = 2'b01;
            vecs[i].exp_out = 4'(16 - i);
            vecs[i].exp_ovf = (i == 8);
        end
        vecs[16] = '{4'b1010, 2'b10, 4'b0110, 1'b0};
        vecs[17] = '{4'b0101, 2'b10, 4'b0101, 1'b0};
        vecs[18] = '{4'b1110, 2'b00, 4'b1110, 1'b0};
        vecs[19] = '{4'b1001, 2'b11, 4'b1001, 1'b0};
        vecs[20] = '{4'b1000, 2'b10, 4'b1000, 1'b1};
        vecs[21] = '{4'b1000, 2'b00, 4'b1000, 1'b0};

        // Reset state.
        rst_n = 1'b0;
        #12;
        check("rst_in_ready", {31'd0, in_ready4}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid4}, 32'd0);
        check("rst_busy", {31'd0, busy4}, 32'd0);
        check("rst_out", {28'd0, out4}, 32'd0);
        check("rst_ovf", {31'd0, ovf4}, 32'd0);

        // Release at a negedge and accept on the very next rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        run_word4(4'b0011, 2'b01, 4'b1101, 1'b0, 1'b0);

        for (int i = 0; i < 22; i++) begin
            run_word4(vecs[i].in_v, vecs[i].mode_v, vecs[i].exp_out, vecs[i].exp_ovf, 1'b0);
        end

        // Inputs changed right after accept must not leak into the result.
        run_word4(4'b0011, 2'b01, 4'b1101, 1'b0, 1'b1);
        run_word4(4'b1010, 2'b10, 4'b0110, 1'b0, 1'b1);

        // W=8 back-pressure with stray in_valid pulses.
        in_valid8 = 1'b1; in8 = 8'h01; mode8 = 2'b01; out_ready8 = 1'b0;
        @(posedge clk);
        #1;
        in8 = 8'h7F; mode8 = 2'b00;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (out_valid8) begin
                lat = k;
                break;
            end
        end
        check("w8_latency", lat, 32'd8);
        check("w8_out", {24'd0, out8}, 32'h0000_00FF);
        check("w8_ovf", {31'd0, ovf8}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            in8 = 8'h55;
            @(posedge clk);
            #1;
            check("w8_hold_valid", {31'd0, out_valid8}, 32'd1);
            check("w8_hold_out", {24'd0, out8}, 32'h0000_00FF);
            check("w8_hold_ready", {31'd0, in_ready8}, 32'd0);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk);
        #1;
        check("w8_release_ready", {31'd0, in_ready8}, 32'd1);
        out_ready8 = 1'b0;
        @(posedge clk);
        #1;
        check("w8_no_capture_busy", {31'd0, busy8}, 32'd0);
        check("w8_no_capture_valid", {31'd0, out_valid8}, 32'd0);

        // Reset mid-SHIFT discards the word.
        @(negedge clk);
        in_valid4 = 1'b1; in4 = 4'b0110; mode4 = 2'b01; out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy4}, 32'd0);
        check("midrst_out", {28'd0, out4}, 32'd0);
        check("midrst_ovf", {31'd0, ovf4}, 32'd0);
        check("midrst_valid", {31'd0, out_valid4}, 32'd0);
        check("midrst_ready", {31'd0, in_ready4}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (out_valid4 || busy4) lat++;
        end
        check("midrst_no_valid_after", lat, 32'd0);
        @(negedge clk);
        run_word4(4'b0110, 2'b01, 4'b1010, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_twos_complement.md
SERIAL_TWOS_COMPLEMENT -- requirements
Module: serial_twos_complement

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning data word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CW, default $clog2(W+1), meaning bit-counter width.
REQ-003 Port clk  input  1  meaning single rising-edge clock for all state.
REQ-004 Port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  meaning In and mode are valid.
REQ-006 Port in_ready  output  1  meaning block can accept a word.
REQ-007 Port In  input  W  meaning operand, two's complement.
REQ-008 Port mode  input  2  meaning 00 PASS, 01 NEGATE, 10 ABS, 11 reserved (treated as PASS).
REQ-009 Port out_valid  output  1  meaning Out and ovf are valid.
REQ-010 Port out_ready  input  1  meaning consumer accepts the result.
REQ-011 Port Out  output  W  meaning result word.
REQ-012 Port ovf  output  1  meaning result not representable (most-negative input negated).
REQ-013 Port busy  output  1  meaning high in SHIFT state.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, DONE; one word in flight at a time, no overlap.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; busy SHALL be 1 only in SHIFT.
REQ-016 A word SHALL be accepted on a rising edge where in_valid && in_ready; In and mode are registered at that edge; state -> SHIFT, bit counter -> 0, "seen-one" flag -> 0.
REQ-017 Operation select SHALL be fixed at accept: invert-enable = (mode==01) or (mode==10 and In[W-1]==1); otherwise pass-through.
REQ-018 In SHIFT, each edge SHALL process one bit LSB-first: output bit = input bit XOR (invert-enable AND seen-one); seen-one is then set if input bit == 1 (copy up to and including first 1, invert thereafter).
REQ-019 After exactly W SHIFT edges the state SHALL go to DONE; out_valid rises W edges after the accepting edge; Out is fully formed at that point and held stable throughout DONE.
REQ-020 ovf SHALL be 1 iff invert-enable and registered In == 1 followed by W-1 zeros; Out then equals that same value; ovf is held with Out.
REQ-021 Negating zero SHALL yield Out=0, ovf=0; PASS SHALL yield Out=In, ovf=0.
REQ-022 In DONE, an edge with out_ready=1 SHALL return state to IDLE; out_ready=0 SHALL hold DONE, Out and ovf indefinitely.
REQ-023 in_valid during SHIFT or DONE SHALL be ignored (no capture, no state change); out_ready outside DONE SHALL be ignored.
REQ-024 In/mode changes after the accept edge SHALL NOT affect the result in flight.
REQ-025 The bit counter SHALL not wrap: it counts 0..W-1 and is cleared on accept.

Reset
REQ-026 rst_n low SHALL immediately (without clock) force state IDLE, counter 0, seen-one 0, Out 0, ovf 0, out_valid 0, busy 0, in_ready 1 on release.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL discard the word in flight; no out_valid is produced for it.
REQ-028 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 W=4, mode=01, In=0011, out_ready=1 -> out_valid high 4 edges after accept, Out=1101, ovf=0, in_ready back high one edge later.
REQ-030 W=4, mode=01, exhaustive In=0000..1111 -> Out = (-In) mod 16 each time; ovf=1 only for In=1000 (Out=1000).
REQ-031 W=4, mode=10, In=1010 -> Out=0110, ovf=0; In=0101 -> Out=0101; mode=00, In=1110 -> Out=1110.
REQ-032 W=8, mode=01, In=0x01, out_ready held 0 for 5 cycles -> Out=0xFF held stable with out_valid=1 all 5 cycles; in_valid pulses during SHIFT/DONE not captured.
REQ-033 W=4, accept In=0110, assert rst_n low after 2 SHIFT edges -> all outputs at reset values at once, no out_valid afterwards; new accept after release completes normally.
REQ-034 W=4, change In and mode on the cycle after accept -> result matches values captured at accept.
